// File: rtl/qspis_pkg.sv
// rtl/qspis_pkg.sv - shared types and constants for the SPI slave clock/frame detector
package qspis_pkg;

    // Frame state of the clock detector
    typedef enum logic {
        CLKDET_IDLE,
        CLKDET_ACTIVE
    } clkdet_state_e;

    // Bits per SPI byte and the width of the in-byte bit counter
    localparam int BYTE_BITS = 8;
    localparam int BIT_W     = $clog2(BYTE_BITS);

endpackage

// File: rtl/qspis_sync.sv
// rtl/qspis_sync.sv - multi-flop synchroniser for an asynchronous pad input
module qspis_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain;

    // Shift the pad level through the chain; reset presets the idle level so
    // no spurious edge is seen while the chain fills.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], din};
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/qspis_clkdet.sv
// rtl/qspis_clkdet.sv - slave-side SPI clock/frame detector (sck edges, csn framing, bit/byte count, idle timeout)
module qspis_clkdet
    import qspis_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TO_W        = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            spi_sck,
    input  logic            spi_csn,
    input  logic [TO_W-1:0] cfg_idle_timeout,
    output logic            sck_rise,
    output logic            sck_fall,
    output logic            cs_active,
    output logic            cs_start,
    output logic            cs_end,
    output logic            cs_end_partial,
    output logic [2:0]      bit_cnt,
    output logic            byte_done,
    output logic            sck_idle,
    output logic            idle_timeout
);

    // Cycles after reset release until both the sync chain and its delayed
    // copy reflect the real pad level rather than the preset idle level.
    localparam int               FL_W  = $clog2(SYNC_STAGES + 2);
    localparam logic [FL_W-1:0]  FLUSH = FL_W'(SYNC_STAGES + 1);

    logic sck_s, csn_s;
    logic sck_d, csn_d;

    logic [FL_W-1:0] flush_cnt;
    logic            armed;

    clkdet_state_e   state_q, state_d;

    logic [TO_W-1:0] to_cnt, to_cnt_d, to_next;
    logic            timed_out, timed_out_d;

    logic            sck_rise_d, sck_fall_d, cs_start_d, cs_end_d, cs_end_partial_d;
    logic            byte_done_d, sck_idle_d, idle_timeout_d;
    logic [2:0]      bit_cnt_d;

    logic            sck_rise_det, sck_fall_det, csn_fall_det, csn_rise_det;

    qspis_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_sck),
        .dout (sck_s)
    );

    qspis_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_csn),
        .dout (csn_s)
    );

    // One-cycle delayed copies of the synchronised levels for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_d <= 1'b1;
            csn_d <= 1'b1;
        end else begin
            sck_d <= sck_s;
            csn_d <= csn_s;
        end
    end

    // Arm frame detection only once a genuine csn high has been observed after
    // reset, so a csn already low at reset release cannot open a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
            armed     <= 1'b0;
        end else begin
            if (flush_cnt != FLUSH) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if (flush_cnt == FLUSH && csn_s && csn_d) begin
                armed <= 1'b1;
            end
        end
    end

    assign sck_rise_det = sck_s & ~sck_d;
    assign sck_fall_det = ~sck_s & sck_d;
    assign csn_fall_det = armed & csn_d & ~csn_s;
    assign csn_rise_det = ~csn_d & csn_s;

    assign to_next = (to_cnt == {TO_W{1'b1}}) ? to_cnt : to_cnt + 1'b1;

    // Next-state and next-output decode; csn events take priority over sck edges
    always_comb begin
        state_d          = state_q;
        sck_rise_d       = 1'b0;
        sck_fall_d       = 1'b0;
        cs_start_d       = 1'b0;
        cs_end_d         = 1'b0;
        cs_end_partial_d = 1'b0;
        byte_done_d      = 1'b0;
        idle_timeout_d   = 1'b0;
        bit_cnt_d        = bit_cnt;
        sck_idle_d       = sck_idle;
        to_cnt_d         = to_cnt;
        timed_out_d      = timed_out;

        case (state_q)
            CLKDET_IDLE: begin
                if (csn_fall_det) begin
                    state_d     = CLKDET_ACTIVE;
                    cs_start_d  = 1'b1;
                    bit_cnt_d   = '0;
                    to_cnt_d    = '0;
                    sck_idle_d  = 1'b0;
                    timed_out_d = 1'b0;
                end
            end
            CLKDET_ACTIVE: begin
                if (csn_rise_det) begin
                    state_d          = CLKDET_IDLE;
                    cs_end_d         = 1'b1;
                    cs_end_partial_d = (bit_cnt != 3'd0);
                    sck_idle_d       = 1'b1;
                end else if (sck_rise_det || sck_fall_det) begin
                    sck_rise_d  = sck_rise_det;
                    sck_fall_d  = sck_fall_det;
                    to_cnt_d    = '0;
                    sck_idle_d  = 1'b0;
                    timed_out_d = 1'b0;
                    if (sck_rise_det) begin
                        bit_cnt_d   = bit_cnt + 3'd1;
                        byte_done_d = (bit_cnt == 3'(BYTE_BITS - 1));
                    end
                end else begin
                    to_cnt_d = to_next;
                    if (cfg_idle_timeout != '0 && to_next == cfg_idle_timeout && !timed_out) begin
                        idle_timeout_d = 1'b1;
                        sck_idle_d     = 1'b1;
                        timed_out_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = CLKDET_IDLE;
            end
        endcase
    end

    // State, counters and all outputs registered together
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= CLKDET_IDLE;
            sck_rise       <= 1'b0;
            sck_fall       <= 1'b0;
            cs_start       <= 1'b0;
            cs_end         <= 1'b0;
            cs_end_partial <= 1'b0;
            byte_done      <= 1'b0;
            idle_timeout   <= 1'b0;
            bit_cnt        <= '0;
            sck_idle       <= 1'b1;
            to_cnt         <= '0;
            timed_out      <= 1'b0;
        end else begin
            state_q        <= state_d;
            sck_rise       <= sck_rise_d;
            sck_fall       <= sck_fall_d;
            cs_start       <= cs_start_d;
            cs_end         <= cs_end_d;
            cs_end_partial <= cs_end_partial_d;
            byte_done      <= byte_done_d;
            idle_timeout   <= idle_timeout_d;
            bit_cnt        <= bit_cnt_d;
            sck_idle       <= sck_idle_d;
            to_cnt         <= to_cnt_d;
            timed_out      <= timed_out_d;
        end
    end

    assign cs_active = (state_q == CLKDET_ACTIVE);

endmodule

// File: tb/tb_qspis_clkdet.sv
// tb/tb_qspis_clkdet.sv - directed self-checking bench for qspis_clkdet
module tb_qspis_clkdet;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sck;
    logic       spi_csn;
    logic [7:0] cfg_idle_timeout;
    logic       sck_rise, sck_fall, cs_active, cs_start, cs_end, cs_end_partial;
    logic [2:0] bit_cnt;
    logic       byte_done, sck_idle, idle_timeout;

    int checks = 0;
    int errors = 0;

    int n_rise  = 0;
    int n_fall  = 0;
    int n_start = 0;
    int n_end   = 0;
    int n_to    = 0;

    int b_rise, b_fall, b_start, b_end, b_to;

    qspis_clkdet #(.SYNC_STAGES(2), .TO_W(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .spi_sck          (spi_sck),
        .spi_csn          (spi_csn),
        .cfg_idle_timeout (cfg_idle_timeout),
        .sck_rise         (sck_rise),
        .sck_fall         (sck_fall),
        .cs_active        (cs_active),
        .cs_start         (cs_start),
        .cs_end           (cs_end),
        .cs_end_partial   (cs_end_partial),
        .bit_cnt          (bit_cnt),
        .byte_done        (byte_done),
        .sck_idle         (sck_idle),
        .idle_timeout     (idle_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sck_rise)     n_rise  <= n_rise + 1;
        if (sck_fall)     n_fall  <= n_fall + 1;
        if (cs_start)     n_start <= n_start + 1;
        if (cs_end)       n_end   <= n_end + 1;
        if (idle_timeout) n_to    <= n_to + 1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] flags();
        return {sck_rise, sck_fall, cs_active, cs_start, cs_end,
                cs_end_partial, byte_done, sck_idle, idle_timeout};
    endfunction

    task automatic snap();
        b_rise  = n_rise;
        b_fall  = n_fall;
        b_start = n_start;
        b_end   = n_end;
        b_to    = n_to;
    endtask

    // One full sck period (8 clk) inside a frame with exact-latency checks
    task automatic sck_cycle(input logic [2:0] exp_bit, input logic exp_bd);
        spi_sck = 1'b0;
        step(2);
        chk("fall_early", sck_fall, 1'b0);
        step(1);
        chk("fall_pulse", sck_fall, 1'b1);
        chk("fall_no_rise", sck_rise, 1'b0);
        step(1);
        chk("fall_width", sck_fall, 1'b0);
        spi_sck = 1'b1;
        step(3);
        chk("rise_pulse", sck_rise, 1'b1);
        chk("rise_bit_cnt", bit_cnt, exp_bit);
        chk("rise_byte_done", byte_done, exp_bd);
        step(1);
        chk("rise_width", sck_rise, 1'b0);
    endtask

    // sck period with no checks, for toggling outside a frame
    task automatic sck_toggle();
        spi_sck = 1'b0;
        step(4);
        spi_sck = 1'b1;
        step(4);
    endtask

    initial begin
        rst              = 1'b1;
        spi_sck          = 1'b1;
        spi_csn          = 1'b1;
        cfg_idle_timeout = 8'd0;

        // Reset values
        step(2);
        chk("reset_flags", flags(), 9'b000000010);
        chk("reset_bit_cnt", bit_cnt, 3'd0);

        // Toggles with csn high produce nothing
        rst = 1'b0;
        step(1);
        snap();
        for (int i = 0; i < 4; i++) sck_toggle();
        step(2);
        chk("noframe_rise", n_rise - b_rise, 0);
        chk("noframe_fall", n_fall - b_fall, 0);
        chk("noframe_bit_cnt", bit_cnt, 3'd0);
        chk("noframe_active", cs_active, 1'b0);

        // Frame open and one full byte
        spi_csn = 1'b0;
        step(2);
        chk("start_early", cs_start, 1'b0);
        step(1);
        chk("start_pulse", cs_start, 1'b1);
        chk("start_active", cs_active, 1'b1);
        chk("start_sck_idle", sck_idle, 1'b0);
        step(1);
        chk("start_width", cs_start, 1'b0);
        snap();
        for (int i = 1; i <= 8; i++) sck_cycle(3'(i % 8), i == 8);
        chk("byte_rises", n_rise - b_rise, 8);
        chk("byte_falls", n_fall - b_fall, 8);
        chk("byte_bit_cnt", bit_cnt, 3'd0);

        // Partial byte then close
        for (int i = 1; i <= 5; i++) sck_cycle(3'(i), 1'b0);
        spi_csn = 1'b1;
        step(3);
        chk("end_pulse", cs_end, 1'b1);
        chk("end_partial", cs_end_partial, 1'b1);
        chk("end_bit_cnt", bit_cnt, 3'd5);
        chk("end_active", cs_active, 1'b0);
        chk("end_sck_idle", sck_idle, 1'b1);
        step(1);
        chk("end_width", cs_end, 1'b0);
        chk("end_hold_bit_cnt", bit_cnt, 3'd5);
        step(4);
        spi_csn = 1'b0;
        step(3);
        chk("reopen_start", cs_start, 1'b1);
        chk("reopen_bit_cnt", bit_cnt, 3'd0);
        step(1);

        // Idle timeout of 10 cycles with a 20-cycle stall
        cfg_idle_timeout = 8'd10;
        snap();
        sck_cycle(3'd1, 1'b0);
        step(8);
        chk("to_before", idle_timeout, 1'b0);
        chk("to_before_idle", sck_idle, 1'b0);
        step(1);
        chk("to_pulse", idle_timeout, 1'b1);
        chk("to_sck_idle", sck_idle, 1'b1);
        step(1);
        chk("to_width", idle_timeout, 1'b0);
        step(9);
        chk("to_once", n_to - b_to, 1);
        chk("to_idle_held", sck_idle, 1'b1);
        spi_sck = 1'b0;
        step(3);
        chk("to_resume_fall", sck_fall, 1'b1);
        chk("to_idle_cleared", sck_idle, 1'b0);
        step(1);
        spi_sck = 1'b1;
        step(4);
        chk("to_resume_bit_cnt", bit_cnt, 3'd2);

        // csn rise coincident with sck rise
        cfg_idle_timeout = 8'd0;
        spi_sck = 1'b0;
        step(4);
        snap();
        spi_sck = 1'b1;
        spi_csn = 1'b1;
        step(3);
        chk("tie_end", cs_end, 1'b1);
        chk("tie_no_rise", sck_rise, 1'b0);
        chk("tie_bit_cnt", bit_cnt, 3'd2);
        step(3);
        chk("tie_rise_count", n_rise - b_rise, 0);

        // Reset mid-byte with csn held low through release
        spi_csn = 1'b0;
        step(4);
        chk("rst_open", cs_active, 1'b1);
        for (int i = 1; i <= 3; i++) sck_cycle(3'(i), 1'b0);
        spi_sck = 1'b0;
        step(1);
        rst = 1'b1;
        step(2);
        chk("rst_flags", flags(), 9'b000000010);
        chk("rst_bit_cnt", bit_cnt, 3'd0);
        rst = 1'b0;
        snap();
        step(12);
        spi_sck = 1'b1;
        step(4);
        sck_toggle();
        sck_toggle();
        step(2);
        chk("rst_no_start", n_start - b_start, 0);
        chk("rst_no_end", n_end - b_end, 0);
        chk("rst_no_rise", n_rise - b_rise, 0);
        chk("rst_inactive", cs_active, 1'b0);
        chk("rst_bit_cnt_held", bit_cnt, 3'd0);
        spi_csn = 1'b1;
        step(8);
        spi_csn = 1'b0;
        step(3);
        chk("rst_reopen", cs_start, 1'b1);
        step(1);
        snap();
        for (int i = 1; i <= 8; i++) sck_cycle(3'(i % 8), i == 8);
        chk("rst_byte_rises", n_rise - b_rise, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
